// File: rtl/irq_pkg.sv
// Shared constants, FSM encoding and the bit-7-highest priority encoder
// for the interrupt pending controller.
package irq_pkg;

    localparam int NUM_IRQ = 8;
    localparam int CODE_W  = 3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } irq_state_e;

    // The highest set bit wins because later iterations overwrite earlier ones.
    function automatic logic [CODE_W-1:0] prio_enc(input logic [NUM_IRQ-1:0] vec);
        logic [CODE_W-1:0] code;
        code = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (vec[i]) code = i[CODE_W-1:0];
        end
        return code;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Request-line synchroniser followed by a rising-edge detector.
// The rise output is combinational from flops only.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter int W           = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] req_in,
    output logic [W-1:0] rise
);

    logic [SYNC_STAGES-1:0][W-1:0] sync_q, sync_d;
    logic [W-1:0]                  req_d_q, req_d_d;
    logic [W-1:0]                  req_s;

    assign req_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = req_in;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        req_d_d = req_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            req_d_q <= '0;
        end else begin
            sync_q  <= sync_d;
            req_d_q <= req_d_d;
        end
    end

    assign rise = req_s & ~req_d_q;

endmodule

// File: rtl/irq_pending_ctrl.sv
// Sticky pending capture with mask qualification and a frozen-code
// valid/ack presentation FSM in front of the priority encoder.
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter int                 SYNC_STAGES = 2,
    parameter logic [NUM_IRQ-1:0] RESET_MASK  = 8'hFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] req_in,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_in,
    input  logic               irq_ack,
    output logic               irq_valid,
    output logic [CODE_W-1:0]  irq_code,
    output logic               idle,
    output logic [NUM_IRQ-1:0] pending
);

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] eligible;
    logic [CODE_W-1:0]  sel_code;
    logic [CODE_W-1:0]  code_q;
    logic               valid_q;
    irq_state_e         state_q;
    logic               ack_fire;

    irq_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .W           (NUM_IRQ)
    ) u_sync_edge (
        .clk    (clk),
        .rst    (rst),
        .req_in (req_in),
        .rise   (rise)
    );

    assign ack_fire = valid_q & irq_ack;
    assign eligible = pending_q & mask_q;
    assign sel_code = prio_enc(eligible);

    // A fresh rise on the line being acknowledged keeps it pending.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (rise[i]) begin
                pending_d[i] = 1'b1;
            end else if (ack_fire && (code_q == i[CODE_W-1:0])) begin
                pending_d[i] = 1'b0;
            end
        end
        mask_d = mask_wr ? mask_in : mask_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            mask_q    <= RESET_MASK;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    // The code is captured once on entry to PRESENT and frozen until acked.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            code_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|eligible) begin
                        code_q  <= sel_code;
                        valid_q <= 1'b1;
                        state_q <= ST_PRESENT;
                    end else begin
                        valid_q <= 1'b0;
                    end
                end
                ST_PRESENT: begin
                    if (ack_fire) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign irq_valid = valid_q;
    assign irq_code  = code_q;
    assign pending   = pending_q;
    assign idle      = (state_q == ST_IDLE) && (eligible == '0);

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed checks of capture latency, priority, frozen code, masking,
// set-over-clear on ack and reset mid-handshake.
module tb_irq_pending_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_in;
    logic       mask_wr;
    logic [7:0] mask_in;
    logic       irq_ack;
    logic       irq_valid;
    logic [2:0] irq_code;
    logic       idle;
    logic [7:0] pending;

    int n_cmp = 0;
    int n_err = 0;

    irq_pending_ctrl #(
        .SYNC_STAGES (2),
        .RESET_MASK  (8'hFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .mask_wr   (mask_wr),
        .mask_in   (mask_in),
        .irq_ack   (irq_ack),
        .irq_valid (irq_valid),
        .irq_code  (irq_code),
        .idle      (idle),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs and samples both sit 1 time unit after it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ack_once();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_in = '0; mask_wr = 1'b0; mask_in = '0; irq_ack = 1'b0;
        tick(2);
        rst = 1'b0;
        chk("rst_valid",   irq_valid, 0);
        chk("rst_code",    irq_code,  0);
        chk("rst_pending", pending,   0);
        chk("rst_idle",    idle,      1);

        // single request: pending at k+2, presented at k+3
        req_in = 8'h04;
        tick(3);
        chk("lat_pend_k2",  pending,   8'h04);
        chk("lat_valid_k2", irq_valid, 0);
        tick();
        chk("lat_valid_k3", irq_valid, 1);
        chk("lat_code_k3",  irq_code,  2);
        tick();
        req_in = '0;
        ack_once();
        chk("ack_valid",   irq_valid, 0);
        chk("ack_pending", pending,   8'h00);
        chk("ack_idle",    idle,      1);
        tick();
        chk("ack_idle2",   idle,      1);
        chk("ack_novalid", irq_valid, 0);

        // simultaneous 7 and 0
        req_in = 8'h81;
        tick(4);
        req_in = '0;
        chk("pri_code7", irq_code,  7);
        chk("pri_pend",  pending,   8'h81);
        ack_once();
        chk("pri_gap",   irq_valid, 0);
        chk("pri_pend1", pending,   8'h01);
        tick();
        chk("pri_v0",    irq_valid, 1);
        chk("pri_code0", irq_code,  0);
        ack_once();
        chk("pri_idle",  idle,      1);

        // code frozen while a higher request arrives
        req_in = 8'h08;
        tick(4);
        chk("frz_code3", irq_code, 3);
        req_in = 8'h40;
        tick(4);
        req_in = '0;
        chk("frz_pend",  pending,   8'h48);
        chk("frz_hold",  irq_code,  3);
        chk("frz_vld",   irq_valid, 1);
        ack_once();
        chk("frz_gap",   irq_valid, 0);
        tick();
        chk("frz_code6", irq_code,  6);
        ack_once();
        tick();

        // masked bit latches but is not selected
        mask_wr = 1'b1; mask_in = 8'hFE;
        tick();
        mask_wr = 1'b0;
        req_in = 8'h01;
        tick(4);
        req_in = '0;
        tick();
        chk("msk_pend",  pending,   8'h01);
        chk("msk_idle",  idle,      1);
        chk("msk_vld",   irq_valid, 0);
        ack_once();
        chk("msk_ignack", pending,  8'h01);
        mask_wr = 1'b1; mask_in = 8'hFF;
        tick();
        mask_wr = 1'b0;
        chk("msk_wr_vld", irq_valid, 0);
        chk("msk_wr_idle", idle,     0);
        tick();
        chk("msk_vld1",  irq_valid, 1);
        chk("msk_code0", irq_code,  0);
        ack_once();
        tick();

        // a rise on bit 5 at the same edge as its ack keeps it pending
        req_in = 8'h20;
        tick(4);
        chk("sc_code5", irq_code, 5);
        req_in = '0;
        tick(3);
        req_in = 8'h20;
        tick(2);
        ack_once();
        chk("sc_pend",  pending,   8'h20);
        chk("sc_gap",   irq_valid, 0);
        tick();
        chk("sc_vld",   irq_valid, 1);
        chk("sc_code",  irq_code,  5);
        req_in = '0;
        ack_once();
        tick(3);

        // reset mid-handshake; the presented bit stays up even when masked
        req_in = 8'h30;
        tick(4);
        req_in = '0;
        chk("rh_code5", irq_code, 5);
        chk("rh_pend",  pending,  8'h30);
        mask_wr = 1'b1; mask_in = 8'h00;
        tick();
        mask_wr = 1'b0;
        chk("rh_mskvld", irq_valid, 1);
        chk("rh_mskcode", irq_code, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rh_vld",  irq_valid, 0);
        chk("rh_pend0", pending,  0);
        chk("rh_idle", idle,      1);
        tick(4);
        chk("rh_nogrant", irq_valid, 0);
        // mask must be back to all-enabled
        req_in = 8'h01;
        tick(4);
        req_in = '0;
        chk("rh_mask_vld",  irq_valid, 1);
        chk("rh_mask_code", irq_code,  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
